// File: rtl/ad_capture_ctrl.sv
// rtl/ad_capture_ctrl.sv - ADC capture sequencer and FSMC-side pop/status logic for the AD1/AD2 FIFO pair
module ad_capture_ctrl #(
  parameter logic [15:0] ADDR_CTRL  = 16'h0003,
  parameter logic [15:0] ADDR_DIV   = 16'h0004,
  parameter logic [15:0] ADDR_NUM   = 16'h0005,
  parameter logic [15:0] ADDR_DATA1 = 16'h0006,
  parameter logic [15:0] ADDR_DATA2 = 16'h0008,
  parameter logic [15:0] ADDR_STAT  = 16'h000A,
  parameter int unsigned CLR_CYC    = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CS,
  input  logic        WR_EN,
  input  logic        RD_EN,
  input  logic [15:0] ADDR,
  input  logic [15:0] DATA_IN,
  input  logic        AD1_FULL,
  input  logic        AD2_FULL,
  output logic        FIFO_CLR,
  output logic        AD_WR_EN,
  output logic        AD1_RD_EN,
  output logic        AD2_RD_EN,
  output logic [15:0] STATUS
);

  localparam int CLR_W = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CLEAR   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_FINISH  = 2'd3;

  logic [1:0] cs_sync_q;
  logic [1:0] wr_sync_q;
  logic [1:0] rd_sync_q;
  logic       wr_prev_q;
  logic       rd_prev_q;
  logic       cs_n_s;
  logic       wr_rise;
  logic       rd_rise;
  logic       rd_fall;
  logic       bus_wr;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      cs_sync_q <= 2'b11;
      wr_sync_q <= 2'b00;
      rd_sync_q <= 2'b00;
      wr_prev_q <= 1'b0;
      rd_prev_q <= 1'b0;
    end else begin
      cs_sync_q <= {cs_sync_q[0], CS};
      wr_sync_q <= {wr_sync_q[0], WR_EN};
      rd_sync_q <= {rd_sync_q[0], RD_EN};
      wr_prev_q <= wr_sync_q[1];
      rd_prev_q <= rd_sync_q[1];
    end
  end

  assign cs_n_s  = cs_sync_q[1];
  assign wr_rise = wr_sync_q[1] & ~wr_prev_q;
  assign rd_rise = rd_sync_q[1] & ~rd_prev_q;
  assign rd_fall = ~rd_sync_q[1] & rd_prev_q;
  assign bus_wr  = wr_rise & ~cs_n_s;

  // Programmed registers plus one-cycle command pulses; abort wins over start.
  logic [15:0] div_q;
  logic [15:0] num_q;
  logic        start_q;
  logic        abort_q;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      div_q   <= 16'd1;
      num_q   <= 16'd0;
      start_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      abort_q <= 1'b0;
      if (bus_wr) begin
        case (ADDR)
          ADDR_CTRL: begin
            abort_q <= DATA_IN[1];
            start_q <= DATA_IN[0] & ~DATA_IN[1];
          end
          ADDR_DIV: div_q <= DATA_IN;
          ADDR_NUM: num_q <= DATA_IN;
          default: ;
        endcase
      end
    end
  end

  logic [15:0] rd_addr_q;
  logic        rd_pend_q;
  logic        pop1_q;
  logic        pop2_q;
  logic        pop1_d;
  logic        pop2_d;

  // A status read never pops, even if the address map were made to overlap.
  always_comb begin
    pop1_d = 1'b0;
    pop2_d = 1'b0;
    if (rd_fall && rd_pend_q && (rd_addr_q != ADDR_STAT)) begin
      pop1_d = (rd_addr_q == ADDR_DATA1);
      pop2_d = (rd_addr_q == ADDR_DATA2);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      rd_addr_q <= 16'd0;
      rd_pend_q <= 1'b0;
      pop1_q    <= 1'b0;
      pop2_q    <= 1'b0;
    end else begin
      pop1_q <= pop1_d;
      pop2_q <= pop2_d;
      if (rd_rise && !cs_n_s) begin
        rd_addr_q <= ADDR;
        rd_pend_q <= 1'b1;
      end else if (rd_fall) begin
        rd_pend_q <= 1'b0;
      end
    end
  end

  logic [1:0]       state_q,   state_d;
  logic [15:0]      div_w_q,   div_w_d;
  logic [15:0]      num_w_q,   num_w_d;
  logic [15:0]      div_cnt_q, div_cnt_d;
  logic [15:0]      smp_cnt_q, smp_cnt_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic             done_q,    done_d;
  logic             ovf_q,     ovf_d;
  logic             wr_q,      wr_d;
  logic             clr_q,     clr_d;
  logic [15:0]      status_q,  status_d;
  logic             div_tc;
  logic             any_full;
  logic             last_smp;
  logic             busy;

  assign div_tc   = (div_cnt_q == (div_w_q - 16'd1));
  assign any_full = AD1_FULL | AD2_FULL;
  // 17-bit compare so NUM=16'hFFFF completes without the counter wrapping.
  assign last_smp = (({1'b0, smp_cnt_q} + 17'd1) == {1'b0, num_w_q});
  assign busy     = (state_q == ST_CLEAR) || (state_q == ST_CAPTURE);

  always_comb begin
    state_d   = state_q;
    div_w_d   = div_w_q;
    num_w_d   = num_w_q;
    div_cnt_d = div_cnt_q;
    smp_cnt_d = smp_cnt_q;
    clr_cnt_d = clr_cnt_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    wr_d      = 1'b0;
    if (abort_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_q) begin
            div_w_d   = (div_q == 16'd0) ? 16'd1 : div_q;
            num_w_d   = num_q;
            done_d    = 1'b0;
            ovf_d     = 1'b0;
            clr_cnt_d = '0;
            state_d   = ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (clr_cnt_q == CLR_W'(CLR_CYC - 1)) begin
            div_cnt_d = 16'd0;
            smp_cnt_d = 16'd0;
            state_d   = (num_w_q == 16'd0) ? ST_FINISH : ST_CAPTURE;
          end else begin
            clr_cnt_d = clr_cnt_q + 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (div_tc) begin
            div_cnt_d = 16'd0;
            if (any_full) begin
              ovf_d   = 1'b1;
              state_d = ST_FINISH;
            end else begin
              wr_d      = 1'b1;
              smp_cnt_d = smp_cnt_q + 16'd1;
              if (last_smp) state_d = ST_FINISH;
            end
          end else begin
            div_cnt_d = div_cnt_q + 16'd1;
          end
        end
        default: begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
    clr_d    = (state_d == ST_CLEAR);
    status_d = {13'd0, ovf_q, done_q, busy};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= ST_IDLE;
      div_w_q   <= 16'd1;
      num_w_q   <= 16'd0;
      div_cnt_q <= 16'd0;
      smp_cnt_q <= 16'd0;
      clr_cnt_q <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      wr_q      <= 1'b0;
      clr_q     <= 1'b0;
      status_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      div_w_q   <= div_w_d;
      num_w_q   <= num_w_d;
      div_cnt_q <= div_cnt_d;
      smp_cnt_q <= smp_cnt_d;
      clr_cnt_q <= clr_cnt_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
      wr_q      <= wr_d;
      clr_q     <= clr_d;
      status_q  <= status_d;
    end
  end

  assign FIFO_CLR  = clr_q;
  assign AD_WR_EN  = wr_q;
  assign AD1_RD_EN = pop1_q;
  assign AD2_RD_EN = pop2_q;
  assign STATUS    = status_q;

endmodule

// File: tb/tb_ad_capture_ctrl.sv
// tb/tb_ad_capture_ctrl.sv - scoreboard bench for ad_capture_ctrl
module tb_ad_capture_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        CS = 1'b1;
  logic        WR_EN = 1'b0;
  logic        RD_EN = 1'b0;
  logic [15:0] ADDR = 16'd0;
  logic [15:0] DATA_IN = 16'd0;
  logic        AD1_FULL = 1'b0;
  logic        AD2_FULL = 1'b0;
  logic        FIFO_CLR;
  logic        AD_WR_EN;
  logic        AD1_RD_EN;
  logic        AD2_RD_EN;
  logic [15:0] STATUS;

  ad_capture_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .CS(CS), .WR_EN(WR_EN), .RD_EN(RD_EN),
    .ADDR(ADDR), .DATA_IN(DATA_IN), .AD1_FULL(AD1_FULL), .AD2_FULL(AD2_FULL),
    .FIFO_CLR(FIFO_CLR), .AD_WR_EN(AD_WR_EN), .AD1_RD_EN(AD1_RD_EN),
    .AD2_RD_EN(AD2_RD_EN), .STATUS(STATUS)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;
  int wr_seen = 0;
  int clr_cnt = 0;
  logic clr_prev = 1'b0;
  int wr_q[$];
  int clr_q[$];
  int p1_q[$];
  int p2_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Output monitor: every observed pulse is matched against the scoreboard queues.
  always @(negedge CLK) begin
    if (AD_WR_EN) begin
      wr_seen++;
      if (wr_q.size() == 0) chk("wr_unexpected", wr_q.size(), 1);
      else chk("wr_cycle", cyc, wr_q.pop_front());
    end
    if (FIFO_CLR) begin
      clr_cnt++;
      if (!clr_prev) begin
        if (clr_q.size() == 0) chk("clr_unexpected", clr_q.size(), 1);
        else chk("clr_start", cyc, clr_q.pop_front());
      end
    end
    clr_prev = FIFO_CLR;
    if (AD1_RD_EN) begin
      if (p1_q.size() == 0) chk("pop1_unexpected", p1_q.size(), 1);
      else chk("pop1_cycle", cyc, p1_q.pop_front());
    end
    if (AD2_RD_EN) begin
      if (p2_q.size() == 0) chk("pop2_unexpected", p2_q.size(), 1);
      else chk("pop2_cycle", cyc, p2_q.pop_front());
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr_begin(input logic [15:0] a, input logic [15:0] d, output int k);
    @(negedge CLK);
    CS = 1'b0;
    @(negedge CLK);
    ADDR = a;
    DATA_IN = d;
    WR_EN = 1'b1;
    k = cyc;
  endtask

  task automatic wr_end();
    wait_cyc(4);
    WR_EN = 1'b0;
    wait_cyc(4);
    CS = 1'b1;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    int k;
    wr_begin(a, d, k);
    wr_end();
  endtask

  task automatic bus_read(input logic [15:0] a);
    int f;
    @(negedge CLK);
    CS = 1'b0;
    @(negedge CLK);
    ADDR = a;
    RD_EN = 1'b1;
    wait_cyc(4);
    RD_EN = 1'b0;
    f = cyc;
    if (a == 16'h0006) p1_q.push_back(f + 3);
    if (a == 16'h0008) p2_q.push_back(f + 3);
    wait_cyc(4);
    CS = 1'b1;
  endtask

  // Start after WR_EN rise at t: clear at t+4, first write at t+8+DIV, spacing DIV.
  task automatic push_capture(input int t, input int dv_raw, input int nexp);
    int dv;
    dv = (dv_raw == 0) ? 1 : dv_raw;
    clr_q.push_back(t + 4);
    for (int i = 0; i < nexp; i++) wr_q.push_back(t + 8 + dv + i * dv);
  endtask

  task automatic run_start(input int dv, input int num, input int nexp, output int t);
    bus_write(16'h0004, 16'(dv));
    bus_write(16'h0005, 16'(num));
    wr_begin(16'h0003, 16'h0001, t);
    push_capture(t, dv, nexp);
    wr_end();
  endtask

  task automatic wait_wr(input int n);
    int b;
    b = 0;
    while (wr_seen < n && b < 3000) begin
      @(negedge CLK);
      b++;
    end
    if (wr_seen < n) chk("wr_wait_timeout", wr_seen, n);
  endtask

  function automatic logic [31:0] outs();
    return {12'd0, FIFO_CLR, AD_WR_EN, AD1_RD_EN, AD2_RD_EN, STATUS};
  endfunction

  initial begin
    int t;
    int k;
    int c0;
    int base;

    RST_N = 1'b0;
    wait_cyc(5);
    RST_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      chk("idle_outputs", outs(), 0);
    end

    c0 = clr_cnt;
    run_start(10, 8, 8, t);
    chk("busy_status", STATUS, 16'h0001);
    wait_cyc(100);
    chk("div10_wr_left", wr_q.size(), 0);
    chk("div10_clr_len", clr_cnt - c0, 4);
    chk("div10_status", STATUS, 16'h0002);

    run_start(1, 5, 2, t);
    while (cyc < t + 10) @(negedge CLK);
    AD2_FULL = 1'b1;
    wait_cyc(10);
    chk("ovf_wr_left", wr_q.size(), 0);
    chk("ovf_status", STATUS, 16'h0006);
    AD2_FULL = 1'b0;

    base = wr_seen;
    run_start(5, 100, 100, t);
    wait_wr(base + 20);
    wr_begin(16'h0003, 16'h0002, k);
    // Writes registered up to the cycle the abort pulse is latched still happen.
    while (wr_q.size() > 0 && wr_q[$] > k + 3) void'(wr_q.pop_back());
    wr_end();
    wait_cyc(30);
    chk("abort_wr_left", wr_q.size(), 0);
    chk("abort_status", STATUS, 16'h0000);

    base = wr_seen;
    c0 = clr_cnt;
    run_start(5, 10, 10, t);
    wait_wr(base + 3);
    bus_write(16'h0003, 16'h0001);
    wait_cyc(60);
    chk("restart_wr_left", wr_q.size(), 0);
    chk("restart_clr_len", clr_cnt - c0, 4);
    chk("restart_status", STATUS, 16'h0002);

    bus_read(16'h0006);
    bus_read(16'h0006);
    bus_read(16'h0006);
    bus_read(16'h0008);
    bus_read(16'h000A);
    wait_cyc(6);
    chk("pop1_left", p1_q.size(), 0);
    chk("pop2_left", p2_q.size(), 0);

    run_start(0, 3, 3, t);
    wait_cyc(20);
    chk("div0_wr_left", wr_q.size(), 0);
    chk("div0_status", STATUS, 16'h0002);

    base = wr_seen;
    run_start(3, 50, 50, t);
    wait_wr(base + 5);
    @(negedge CLK);
    #1;
    wr_q.delete();
    RST_N = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_mid_outputs", outs(), 0);
    end
    RST_N = 1'b1;

    c0 = clr_cnt;
    wr_begin(16'h0003, 16'h0001, t);
    push_capture(t, 1, 0);
    wr_end();
    wait_cyc(20);
    chk("num0_clr_len", clr_cnt - c0, 4);
    chk("num0_status", STATUS, 16'h0002);

    bus_write(16'h0005, 16'd2);
    wr_begin(16'h0003, 16'h0001, t);
    push_capture(t, 1, 2);
    wr_end();
    wait_cyc(20);
    chk("divrst_wr_left", wr_q.size(), 0);
    chk("divrst_status", STATUS, 16'h0002);
    chk("clr_left", clr_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
